// File: rtl/relu_pass_ctrl.sv
// relu_pass_ctrl: sequences one ReLU pass, reading a source buffer through an external Relu
// and writing rectified words to a destination buffer with a fixed 2-cycle read-to-write latency.
module relu_pass_ctrl #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_src_base,
   input  logic [ADDR_W-1:0] cfg_dst_base,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic              hold,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] relu_din,
   input  logic [DATA_W-1:0] relu_dout,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   neg_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_src, r_dst;
   logic [ADDR_W:0]   r_len, r_issue, r_wcnt;
   logic              r_v1, r_v2;
   logic              w_frz, w_last_rd, w_last_wr;

   // hold freezes everything except in IDLE, where it must not block a start
   assign w_frz     = hold && (r_state != IDLE);
   assign rd_en     = (r_state == RUN) && !hold;
   assign rd_addr   = r_src + r_issue[ADDR_W-1:0];
   assign wr_en     = r_v2 && !hold;
   assign wr_addr   = r_dst + r_wcnt[ADDR_W-1:0];
   assign relu_din  = rd_data;
   assign busy      = (r_state == RUN) || (r_state == DRAIN);
   assign done      = (r_state == DONE) && !hold;
   assign w_last_rd = rd_en && (r_issue == r_len - 1'b1);
   assign w_last_wr = wr_en && (r_wcnt == r_len - 1'b1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? ((cfg_len == '0) ? DONE : RUN) : IDLE;
         RUN:     w_next = w_last_rd ? DRAIN : RUN;
         DRAIN:   w_next = w_last_wr ? DONE : DRAIN;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_len   <= '0;
         r_issue <= '0;
         r_wcnt  <= '0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         wr_data <= '0;
         neg_cnt <= '0;
      end else if (!w_frz) begin
         r_state <= w_next;
         r_v1    <= rd_en;
         r_v2    <= r_v1;
         if (r_state == IDLE && start) begin
            r_src   <= cfg_src_base;
            r_dst   <= cfg_dst_base;
            r_len   <= cfg_len;
            r_issue <= '0;
            r_wcnt  <= '0;
            neg_cnt <= '0;
         end
         if (rd_en) r_issue <= r_issue + 1'b1;
         if (wr_en) r_wcnt <= r_wcnt + 1'b1;
         if (r_v1) begin
            wr_data <= relu_dout;
            neg_cnt <= neg_cnt + (ADDR_W+1)'(rd_data[DATA_W-1]);
         end
      end
   end
endmodule

// File: tb/tb_relu_pass_ctrl.sv
// tb_relu_pass_ctrl: directed bench for relu_pass_ctrl with a sync-read SRAM and a behavioural Relu.
module tb_relu_pass_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] cfg_src_base = '0;
   logic [11:0] cfg_dst_base = '0;
   logic [12:0] cfg_len = '0;
   logic        hold = 1'b0;
   logic        rd_en, wr_en, busy, done;
   logic [11:0] rd_addr, wr_addr;
   logic [31:0] rd_data = '0;
   logic [31:0] relu_din, relu_dout, wr_data;
   logic [12:0] neg_cnt;

   logic [31:0] mem [4096];
   int          cyc = 0;
   int          n_chk = 0, n_pass = 0;
   int          nr, nw, done_n, done_c, hs, c0;
   logic        done_busy;
   logic [11:0] ra [64];
   logic [11:0] wa [64];
   logic [31:0] wd [64];
   int          wc [64];

   relu_pass_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_len(cfg_len),
      .hold(hold), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .relu_din(relu_din), .relu_dout(relu_dout), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done), .neg_cnt(neg_cnt)
   );

   assign relu_dout = relu_din[31] ? 32'h0 : relu_din;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   always @(negedge clk) begin
      if (rd_en && nr < 64) begin
         ra[nr] = rd_addr;
         nr++;
      end
      if (wr_en && nw < 64) begin
         wa[nw] = wr_addr;
         wd[nw] = wr_data;
         wc[nw] = cyc;
         nw++;
      end
      if (done) begin
         done_n++;
         done_c = cyc;
         done_busy = busy;
      end
      if (hold && (rd_en || wr_en)) hs++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic clr();
      nr = 0;
      nw = 0;
      done_n = 0;
      hs = 0;
      done_busy = 1'b0;
   endtask

   // ha/hl: hold window in cycles after start; sa: cycle of a stray start; ab: abort after ab writes
   task automatic run(input logic [11:0] s, input logic [11:0] d, input logic [12:0] l,
                      input int ha, input int hl, input int sa, input int ab);
      clr();
      cfg_src_base = s;
      cfg_dst_base = d;
      cfg_len = l;
      start = 1'b1;
      c0 = cyc;
      @(posedge clk);
      #2 start = 1'b0;
      for (int k = 0; k < 300 && done_n == 0 && !(ab > 0 && nw >= ab); k++) begin
         hold = (k >= ha) && (k < ha + hl);
         start = (k == sa);
         if (k == sa) begin
            cfg_src_base = 12'h040;
            cfg_dst_base = 12'h140;
            cfg_len = 13'd2;
         end
         @(posedge clk);
         #2;
      end
      hold = 1'b0;
      start = 1'b0;
      if (ab == 0) chk("done_seen", done_n, 1);
   endtask

   task automatic chk_w(input logic [11:0] s, input logic [11:0] d, input int n);
      logic [31:0] x;
      chk("n_reads", nr, n);
      chk("n_writes", nw, n);
      for (int i = 0; i < n && i < 64; i++) begin
         x = mem[s + 12'(i)];
         chk("rd_addr", ra[i], s + 12'(i));
         chk("wr_addr", wa[i], d + 12'(i));
         chk("wr_data", wd[i], x[31] ? 32'h0 : x);
      end
   endtask

   initial begin
      foreach (mem[i]) mem[i] = '0;
      #1;
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_neg_cnt", neg_cnt, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;

      // basic pass
      mem[12'h010] = 32'd5;
      mem[12'h011] = 32'hFFFF_FFFF;
      mem[12'h012] = 32'd0;
      mem[12'h013] = 32'h7FFF_FFFF;
      run(12'h010, 12'h100, 13'd4, 0, 0, -1, 0);
      chk("t1_nw", nw, 4);
      chk("t1_w0", {20'h0, wa[0], wd[0]}, {20'h0, 12'h100, 32'd5});
      chk("t1_w1", {20'h0, wa[1], wd[1]}, {20'h0, 12'h101, 32'd0});
      chk("t1_w2", {20'h0, wa[2], wd[2]}, {20'h0, 12'h102, 32'd0});
      chk("t1_w3", {20'h0, wa[3], wd[3]}, {20'h0, 12'h103, 32'h7FFF_FFFF});
      for (int i = 0; i < 4; i++) chk("t1_wr_cycle", wc[i] - c0, 3 + i);
      chk("t1_neg", neg_cnt, 1);
      chk("t1_done_n", done_n, 1);
      chk("t1_done_at", done_c - c0, 7);
      chk("t1_done_busy", done_busy, 0);
      chk("t1_busy_after", busy, 0);

      // zero length
      run(12'h010, 12'h100, 13'd0, 0, 0, -1, 0);
      chk("t2_done_at", done_c - c0, 1);
      chk("t2_nr", nr, 0);
      chk("t2_nw", nw, 0);
      chk("t2_neg", neg_cnt, 0);

      // hold mid-run
      mem[12'h200] = 32'h11;
      mem[12'h201] = 32'h8000_0001;
      mem[12'h202] = 32'h22;
      mem[12'h203] = 32'hFFFF_0000;
      mem[12'h204] = 32'h33;
      mem[12'h205] = 32'h7FFF_FFFF;
      mem[12'h206] = 32'h8000_0000;
      mem[12'h207] = 32'h44;
      run(12'h200, 12'h300, 13'd8, 2, 3, -1, 0);
      chk("t3_hold_strobes", hs, 0);
      chk_w(12'h200, 12'h300, 8);
      chk("t3_neg", neg_cnt, 3);
      chk("t3_done_at", done_c - c0, 14);

      // address wrap
      mem[12'hFFE] = 32'h8000_0000;
      mem[12'hFFF] = 32'h1;
      mem[12'h000] = 32'h2;
      run(12'hFFE, 12'hFFF, 13'd3, 0, 0, -1, 0);
      chk("t4_ra", {ra[0], ra[1], ra[2]}, {12'hFFE, 12'hFFF, 12'h000});
      chk("t4_wa", {wa[0], wa[1], wa[2]}, {12'hFFF, 12'h000, 12'h001});
      chk("t4_wd", {wd[0], wd[1], wd[2]}, {32'h0, 32'h1, 32'h2});
      chk("t4_neg", neg_cnt, 1);
      chk("t4_done_at", done_c - c0, 6);

      // stray start while running, cfg changed afterwards
      mem[12'h020] = 32'h1;
      mem[12'h021] = 32'h2;
      mem[12'h022] = 32'hF000_0000;
      mem[12'h023] = 32'h3;
      mem[12'h024] = 32'h4;
      run(12'h020, 12'h120, 13'd5, 0, 0, 1, 0);
      chk_w(12'h020, 12'h120, 5);
      chk("t5_neg", neg_cnt, 1);
      chk("t5_done_n", done_n, 1);
      chk("t5_done_at", done_c - c0, 8);

      // reset mid-pass
      for (int i = 0; i < 10; i++) mem[12'h050 + 12'(i)] = 32'h100 + 32'(i);
      mem[12'h051] = 32'h8000_0005;
      run(12'h050, 12'h150, 13'd10, 0, 0, -1, 2);
      chk("t6_pre_nw", nw, 2);
      chk("t6_pre_neg", neg_cnt, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rd_en", rd_en, 0);
      chk("t6_wr_en", wr_en, 0);
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_rd_addr", rd_addr, 0);
      chk("t6_wr_addr", wr_addr, 0);
      chk("t6_wr_data", wr_data, 0);
      chk("t6_neg_cnt", neg_cnt, 0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("t6_no_done", done_n, 0);
      mem[12'h060] = 32'h9;
      mem[12'h061] = 32'h9000_0000;
      run(12'h060, 12'h160, 13'd2, 0, 0, -1, 0);
      chk_w(12'h060, 12'h160, 2);
      chk("t6_neg2", neg_cnt, 1);
      chk("t6_done_at", done_c - c0, 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/relu_pass_ctrl.md
Name: relu_pass_ctrl

Overview:
Sequencer that runs one ReLU pass over a feature map held in a synchronous single-port-read SRAM and writes the rectified results to a destination buffer.
It drives an external combinational Relu instance: read data goes out on relu_din, the rectified value comes back on relu_dout.
The pipeline issues one read per cycle and has a fixed read-to-write latency of 2 cycles.
Sits between the layer controller (start/done/config) and the feature-map memories.

Parameters:
ADDR_W, 12, address width of source and destination buffers
DATA_W, 32, data width; equals `INTERNAL_BITS

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  1-cycle pulse; launches a pass when idle
cfg_src_base  input  ADDR_W  first source address
cfg_dst_base  input  ADDR_W  first destination address
cfg_len  input  ADDR_W+1  element count, 0..2^ADDR_W
hold  input  1  pipeline freeze request
rd_en  output  1  source read strobe
rd_addr  output  ADDR_W  source read address
rd_data  input  DATA_W  source data, valid 1 cycle after rd_en
relu_din  output  DATA_W  to Relu Data_in; combinationally equal to rd_data
relu_dout  input  DATA_W  from Relu Data_out
wr_en  output  1  destination write strobe
wr_addr  output  ADDR_W  destination address
wr_data  output  DATA_W  registered rectified data
busy  output  1  high from the cycle after an accepted start until done
done  output  1  1-cycle completion pulse
neg_cnt  output  ADDR_W+1  count of elements with sign bit set in the last pass

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0: rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data, neg_cnt.
  - All internal counters 0.
- Config capture: cfg_* are sampled only on the clock edge where start=1 in IDLE. Later changes have no effect on the pass in progress.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 with cfg_len>0 -> RUN, clear neg_cnt. start=1 with cfg_len=0 -> DONE, no memory access.
  - RUN: rd_en=1 and rd_addr=src_base+issue_cnt each non-held cycle; issue_cnt increments. After issuing read cfg_len-1 -> DRAIN.
  - DRAIN: no reads. Stays until the last write has been issued -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in that cycle -> IDLE.
- Pipeline, for a read issued at cycle t:
  - t+1: rd_data valid; relu_dout captured into wr_data at the end of t+1. neg_cnt increments if rd_data[DATA_W-1]=1.
  - t+2: wr_en=1, wr_addr=dst_base+k, where k is the element index.
- Hold: while hold=1, every register freezes: FSM, counters, wr_data, neg_cnt.
  - rd_en and wr_en are forced 0 during hold.
  - rd_data must be held stable by the memory during hold. The element sampled at t+1 is taken on the first non-held cycle after its read.
- Address arithmetic: modulo 2^ADDR_W; base+index wraps silently.
- Edge cases:
  - start while busy or in DONE is ignored.
  - hold in IDLE has no effect.
  - Sign test uses bit DATA_W-1 only.
  - 0x80000000 is counted as negative and written as 0.
- Reset mid-pass aborts immediately: no done pulse; the next start begins a fresh pass.
- Throughput without hold: cfg_len writes in cfg_len+2 cycles after start. done asserts at cycle start+cfg_len+3.

Test Plan:
1. len=4, src=0x010, dst=0x100, data {5, 0xFFFFFFFF, 0, 0x7FFFFFFF}:
   - writes {5, 0, 0, 0x7FFFFFFF} to 0x100..0x103 on consecutive cycles;
   - neg_cnt=1; done exactly once, 7 cycles after start.
2. cfg_len=0: done pulses 1 cycle after start; rd_en and wr_en never assert; neg_cnt=0.
3. len=8 with hold asserted for 3 cycles mid-RUN: no strobes during hold; all 8 writes correct and in order; done delayed by exactly 3 cycles.
4. src=0xFFE, dst=0xFFF, len=3: reads 0xFFE, 0xFFF, 0x000; writes 0xFFF, 0x000, 0x001.
5. Second start pulse during RUN, with different cfg: ignored; the original pass completes unchanged.
6. rst_n low after 2 writes of a len=10 pass: all outputs 0 immediately, no done; a new pass with len=2 then runs correctly.
